uart_param_loader: RTL and testbench

//  Upstream feeder of the GPU register file. Receives the per-frame scene packet over UART
//  (8N1), frames it with a sync byte and a trailing checksum, and emits one indexed byte

---
 rtl/tiniest_gpu_pkg.sv | 29 ++
 rtl/uart_rx_byte.sv | 82 ++++++++
 rtl/uart_param_loader.sv | 114 +++++++++++
 tb/tb_uart_param_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tiniest_gpu_pkg.sv
// Shared types and constants for the GPU front end.
// Holds state encodings, packet framing values and the register index map.
package tiniest_gpu_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        P_SYNC,
        P_LOAD,
        P_CHK
    } pkt_state_t;

    localparam int          BAUD_DIV_DEF  = 347;
    localparam int          NUM_BYTES_DEF = 60;
    localparam int          TIMEOUT_DEF   = 40000;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    localparam logic [6:0]  IDX_X_V0_LO     = 7'd0;
    localparam logic [6:0]  IDX_X_V0_HI     = 7'd1;
    localparam logic [6:0]  IDX_Y_V0_LO     = 7'd2;
    localparam logic [6:0]  IDX_Y_V0_HI     = 7'd3;
    localparam logic [6:0]  IDX_RENDER_MODE = 7'd59;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, baud counter, bit FSM.
// byte_valid/frame_err are 1-clk strobes coincident with the stop-bit sample.
module uart_rx_byte
    import tiniest_gpu_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] MID  = CW'(BAUD_DIV / 2 - 1);

    rx_state_t     state, state_n;
    logic          rx_meta, rx_s, rx_q;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          tick;

    assign tick = (state == R_START) ? (cnt == MID) : (cnt == LAST);
    assign data = shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
            state   <= R_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
            state   <= state_n;
            if (state == R_IDLE || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (state == R_IDLE) begin
                bit_cnt <= '0;
            end else if (state == R_DATA && tick) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        unique case (state)
            R_IDLE: begin
                if (rx_q && !rx_s) state_n = R_START;
            end
            R_START: begin
                if (tick) state_n = rx_s ? R_IDLE : R_DATA;
            end
            R_DATA: begin
                if (tick && bit_cnt == 3'd7) state_n = R_STOP;
            end
            R_STOP: begin
                if (tick) begin
                    state_n    = R_IDLE;
                    byte_valid = rx_s;
                    frame_err  = !rx_s;
                end
            end
        endcase
    end

endmodule

// File: rtl/uart_param_loader.sv
// Scene-packet loader: sync byte, NUM_BYTES payload writes, checksum byte.
// Emits indexed register writes and a pc_ready pulse on a valid packet.
module uart_param_loader
    import tiniest_gpu_pkg::*;
#(
    parameter int         BAUD_DIV  = BAUD_DIV_DEF,
    parameter int         NUM_BYTES = NUM_BYTES_DEF,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         TIMEOUT   = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] read_data,
    output logic [6:0] idx,
    output logic       update_reg,
    output logic       pc_ready,
    output logic       pkt_err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [6:0]    CNT_END = 7'(NUM_BYTES - 1);

    pkt_state_t    pstate, pstate_n;
    logic [6:0]    cnt, cnt_n, idx_n;
    logic [7:0]    sum, sum_n, data_n, sum_nx;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          wr_n, pc_n, err_n;
    logic [7:0]    rx_data;
    logic          byte_valid, frame_err;

    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (rx_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign sum_nx = sum + rx_data;
    assign busy   = (pstate != P_SYNC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate     <= P_SYNC;
            cnt        <= '0;
            sum        <= '0;
            tcnt       <= '0;
            read_data  <= '0;
            idx        <= '0;
            update_reg <= 1'b0;
            pc_ready   <= 1'b0;
            pkt_err    <= 1'b0;
        end else begin
            pstate     <= pstate_n;
            cnt        <= cnt_n;
            sum        <= sum_n;
            tcnt       <= tcnt_n;
            read_data  <= data_n;
            idx        <= idx_n;
            update_reg <= wr_n;
            pc_ready   <= pc_n;
            pkt_err    <= err_n;
        end
    end

    always_comb begin
        pstate_n = pstate;
        cnt_n    = cnt;
        sum_n    = sum;
        tcnt_n   = tcnt;
        data_n   = read_data;
        idx_n    = idx;
        wr_n     = 1'b0;
        pc_n     = 1'b0;
        err_n    = 1'b0;
        case (pstate)
            P_SYNC: begin
                if (byte_valid && rx_data == SYNC_BYTE) begin
                    pstate_n = P_LOAD;
                    cnt_n    = '0;
                    sum_n    = '0;
                    tcnt_n   = '0;
                end
            end
            default: begin
                if (frame_err || (!byte_valid && tcnt >= TO_LAST)) begin
                    err_n    = 1'b1;
                    pstate_n = P_SYNC;
                end else if (byte_valid) begin
                    tcnt_n = '0;
                    if (pstate == P_LOAD) begin
                        wr_n   = 1'b1;
                        data_n = rx_data;
                        idx_n  = cnt;
                        sum_n  = sum_nx;
                        cnt_n  = cnt + 7'd1;
                        if (cnt == CNT_END) pstate_n = P_CHK;
                    end else begin
                        pc_n     = (sum_nx == 8'd0);
                        err_n    = (sum_nx != 8'd0);
                        pstate_n = P_SYNC;
                    end
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_uart_param_loader.sv
// Scoreboard bench for uart_param_loader with a shortened baud divider.
// Expected writes are queued as bytes are sent and popped on update_reg.
module tb_uart_param_loader;

    localparam int         BD   = 10;
    localparam int         NB   = 60;
    localparam int         TO   = 1200;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] read_data;
    logic [6:0] idx;
    logic       update_reg, pc_ready, pkt_err, busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_wr = 0, n_pc = 0, n_err = 0;
    int wr_cyc = 0, pc_cyc = 0, err_cyc = 0;
    logic [14:0] sb[$];
    logic [14:0] exp_wr;

    uart_param_loader #(
        .BAUD_DIV  (BD),
        .NUM_BYTES (NB),
        .SYNC_BYTE (SYNC),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .read_data  (read_data),
        .idx        (idx),
        .update_reg (update_reg),
        .pc_ready   (pc_ready),
        .pkt_err    (pkt_err),
        .busy       (busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (update_reg) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    exp_wr = sb.pop_front();
                    chk("wr_idx", 32'(idx), 32'(exp_wr[14:8]));
                    chk("wr_data", 32'(read_data), 32'(exp_wr[7:0]));
                end
                chk("wr_excl", {pc_ready, pkt_err}, 0);
                n_wr++;
                wr_cyc = cyc;
            end
            if (pc_ready || pkt_err) chk("pulse_excl", pc_ready & pkt_err, 0);
            if (pc_ready) begin
                n_pc++;
                pc_cyc = cyc;
            end
            if (pkt_err) begin
                n_err++;
                err_cyc = cyc;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_clk(BD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(BD);
        end
        rx = stop;
        wait_clk(BD);
    endtask

    task automatic send_payload(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back({7'(i), 8'(i)});
            send_byte(8'(i), 1'b1);
        end
    endtask

    task automatic run_pkt(input logic good);
        int w0, p0, e0;
        logic [7:0] sum, ck;
        w0 = n_wr; p0 = n_pc; e0 = n_err;
        sum = 8'd0;
        for (int i = 0; i < NB; i++) sum = sum + 8'(i);
        ck = 8'd0 - sum + (good ? 8'd0 : 8'd1);
        send_byte(SYNC, 1'b1);
        chk("busy_hi", busy, 1);
        send_payload(NB);
        send_byte(ck, 1'b1);
        wait_clk(BD);
        chk("pkt_wr", n_wr - w0, NB);
        chk("pkt_pc", n_pc - p0, good ? 1 : 0);
        chk("pkt_err", n_err - e0, good ? 0 : 1);
        chk("busy_lo", busy, 0);
        if (good) chk("pc_lat", pc_cyc - wr_cyc, 10 * BD);
        else      chk("err_lat", err_cyc - wr_cyc, 10 * BD);
    endtask

    initial begin
        #(150000 * 20);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int w0, p0, e0;
        bit seen;
        rst_n = 1'b0;
        wait_clk(5);
        chk("rst_out", {read_data, idx, update_reg, pc_ready, pkt_err, busy}, 0);
        rst_n = 1'b1;
        wait_clk(10000);
        chk("idle_out", {read_data, idx, update_reg, pc_ready, pkt_err, busy}, 0);
        chk("idle_pulses", n_wr + n_pc + n_err, 0);

        run_pkt(1'b1);
        run_pkt(1'b0);
        run_pkt(1'b1);

        w0 = n_wr; e0 = n_err;
        rx = 1'b0;
        wait_clk(3);
        rx = 1'b1;
        wait_clk(5 * BD);
        send_byte(8'h11, 1'b1);
        wait_clk(2 * BD);
        chk("glitch_wr", n_wr - w0, 0);
        chk("glitch_err", n_err - e0, 0);
        chk("glitch_busy", busy, 0);
        run_pkt(1'b1);

        w0 = n_wr; e0 = n_err;
        send_byte(SYNC, 1'b1);
        send_payload(10);
        seen = 1'b0;
        for (int i = 0; i < TO + 200 && !seen; i++) begin
            wait_clk(1);
            seen = (n_err != e0);
        end
        chk("to_seen", n_err - e0, 1);
        chk("to_lat", err_cyc - wr_cyc, TO);
        chk("to_wr", n_wr - w0, 10);
        chk("to_busy", busy, 0);
        run_pkt(1'b1);

        w0 = n_wr; p0 = n_pc; e0 = n_err;
        send_byte(SYNC, 1'b1);
        send_payload(5);
        send_byte(8'd5, 1'b0);
        rx = 1'b1;
        wait_clk(3 * BD);
        chk("fe_err", n_err - e0, 1);
        chk("fe_pc", n_pc - p0, 0);
        chk("fe_wr", n_wr - w0, 5);
        chk("fe_busy", busy, 0);

        w0 = n_wr; p0 = n_pc; e0 = n_err;
        send_byte(SYNC, 1'b1);
        send_payload(1);
        rx = 1'b0;
        wait_clk(4 * BD);
        rst_n = 1'b0;
        wait_clk(2);
        chk("mid_rst_out",
            {read_data, idx, update_reg, pc_ready, pkt_err, busy}, 0);
        rx = 1'b1;
        wait_clk(BD);
        rst_n = 1'b1;
        wait_clk(12 * BD);
        chk("rst_wr", n_wr - w0, 1);
        chk("rst_pulses", (n_pc - p0) + (n_err - e0), 0);
        chk("rst_busy", busy, 0);
        run_pkt(1'b1);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
